// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline controller.
// Register index width and controller FSM states.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        LDSTALL,
        BRPEND,
        HALT
    } pctrl_state_t;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: a load in ID/EX writes a register
// that the instruction in IF/ID reads.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     i_dren,
    input  regbits_t i_wsel,
    input  regbits_t i_rs,
    input  regbits_t i_rt,
    output logic     o_load_use
);

    logic w_nonzero;
    logic w_match;

    assign w_nonzero  = (i_wsel != '0);
    assign w_match    = (i_wsel == i_rs) || (i_wsel == i_rt);
    assign o_load_use = i_dren && w_nonzero && w_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: stage enables, flushes,
// halt tracking and a saturating stall counter.
module pipeline_ctrl
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        memreqMEM,
    input  logic        dRENEX,
    input  logic [4:0]  wselEX,
    input  logic [4:0]  rsDEC,
    input  logic [4:0]  rtDEC,
    input  logic        takenEX,
    input  logic        haltMEM,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic [31:0] stall_cnt
);

    pctrl_state_t r_state;
    pctrl_state_t w_next;
    logic         r_halted;
    logic [31:0]  r_stall_cnt;
    logic         w_freeze;
    logic         w_load_use;

    hazard_detect u_hazard (
        .i_dren     (dRENEX),
        .i_wsel     (wselEX),
        .i_rs       (rsDEC),
        .i_rt       (rtDEC),
        .o_load_use (w_load_use)
    );

    assign w_freeze  = memreqMEM && !dhit;
    assign halted    = r_halted;
    assign stall_cnt = r_stall_cnt;

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        w_next     = r_state;
        if (RST) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            w_next     = RUN;
        end else begin
            unique case (r_state)
                HALT: w_next = HALT;
                BRPEND: begin
                    // Branch waits out the data access, then squashes.
                    if (dhit) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        w_next     = RUN;
                    end
                end
                RUN, LDSTALL: begin
                    w_next = RUN;
                    if (w_freeze) begin
                        if (takenEX) w_next = BRPEND;
                    end else if (takenEX) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (w_load_use && r_state == RUN) begin
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        idex_flush = 1'b1;
                        w_next     = LDSTALL;
                    end else if (!ihit) begin
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                    end else begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end
                end
                default: w_next = RUN;
            endcase
            if (haltMEM && exmem_en) w_next = HALT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= RUN;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_halted <= (w_next == HALT);
            if (!pc_en && !r_halted && r_stall_cnt != STALL_CNT_MAX)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each step drives inputs,
// queues the expected outputs and compares before the next edge.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, memreqMEM, dRENEX, takenEX, haltMEM;
    logic [4:0]  wselEX, rsDEC, rtDEC;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, halted;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst, ihit, dhit, memreq, taken, halt, dren;
        logic [4:0] wsel, rs, rt;
        logic [7:0] exp;
        logic [31:0] cnt;
    } step_t;

    typedef struct {
        logic [7:0]  vec;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush,halted}
    localparam logic [7:0] ALL   = 8'b11111_00_0;
    localparam logic [7:0] RSTV  = 8'b00000_11_0;
    localparam logic [7:0] FRZ   = 8'b00000_00_0;
    localparam logic [7:0] FLUSH = 8'b11111_11_0;
    localparam logic [7:0] LDU   = 8'b00111_01_0;
    localparam logic [7:0] IMISS = 8'b01111_10_0;
    localparam logic [7:0] HALTV = 8'b00000_00_1;

    pipeline_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .dhit       (dhit),
        .memreqMEM  (memreqMEM),
        .dRENEX     (dRENEX),
        .wselEX     (wselEX),
        .rsDEC      (rsDEC),
        .rtDEC      (rtDEC),
        .takenEX    (takenEX),
        .haltMEM    (haltMEM),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .idex_en    (idex_en),
        .exmem_en   (exmem_en),
        .memwb_en   (memwb_en),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .halted     (halted),
        .stall_cnt  (stall_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic step_t mk(
        logic rst, logic ih, logic dh, logic mr, logic tk,
        logic hl, logic dr, logic [4:0] ws, logic [4:0] rs,
        logic [4:0] rt, logic [7:0] e, logic [31:0] c);
        step_t s;
        s.rst = rst; s.ihit = ih; s.dhit = dh; s.memreq = mr;
        s.taken = tk; s.halt = hl; s.dren = dr;
        s.wsel = ws; s.rs = rs; s.rt = rt;
        s.exp = e; s.cnt = c;
        return s;
    endfunction

    function automatic step_t idle(logic [7:0] e, logic [31:0] c);
        return mk(0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, e, c);
    endfunction

    task automatic drive(input step_t s);
        exp_t e;
        RST = s.rst; ihit = s.ihit; dhit = s.dhit;
        memreqMEM = s.memreq; takenEX = s.taken;
        haltMEM = s.halt; dRENEX = s.dren;
        wselEX = s.wsel; rsDEC = s.rs; rtDEC = s.rt;
        e.vec = s.exp;
        e.cnt = s.cnt;
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] obs();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, halted};
    endfunction

    task automatic test_reset();
        step_t t[$];
        exp_t e;
        t.push_back(mk(1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, RSTV, 32'd0));
        t.push_back(idle(ALL, 32'd0));
        foreach (t[i]) begin
            drive(t[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if ({obs(), stall_cnt} !== {e.vec, e.cnt}) begin
                errors++;
                $display("FAIL reset step %0d: got %b cnt %h, expected %b cnt %h",
                         i, obs(), stall_cnt, e.vec, e.cnt);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_load_use();
        step_t t[$];
        exp_t e;
        t.push_back(mk(0, 1, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, LDU, 32'd0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, ALL, 32'd1));
        t.push_back(idle(ALL, 32'd1));
        foreach (t[i]) begin
            drive(t[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if ({obs(), stall_cnt} !== {e.vec, e.cnt}) begin
                errors++;
                $display("FAIL load_use step %0d: got %b cnt %h, expected %b cnt %h",
                         i, obs(), stall_cnt, e.vec, e.cnt);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reg_zero();
        step_t t[$];
        exp_t e;
        t.push_back(mk(0, 1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, ALL, 32'd1));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd1, ALL, 32'd1));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5, LDU, 32'd1));
        t.push_back(idle(ALL, 32'd2));
        foreach (t[i]) begin
            drive(t[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if ({obs(), stall_cnt} !== {e.vec, e.cnt}) begin
                errors++;
                $display("FAIL reg_zero step %0d: got %b cnt %h, expected %b cnt %h",
                         i, obs(), stall_cnt, e.vec, e.cnt);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_branch_freeze();
        step_t t[$];
        exp_t e;
        t.push_back(mk(0, 1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, FRZ, 32'd2));
        t.push_back(mk(0, 1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, FRZ, 32'd3));
        t.push_back(mk(0, 1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, FRZ, 32'd4));
        t.push_back(mk(0, 1, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, FLUSH, 32'd5));
        t.push_back(idle(ALL, 32'd5));
        foreach (t[i]) begin
            drive(t[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if ({obs(), stall_cnt} !== {e.vec, e.cnt}) begin
                errors++;
                $display("FAIL branch_freeze step %0d: got %b cnt %h, expected %b cnt %h",
                         i, obs(), stall_cnt, e.vec, e.cnt);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_branch_load_use();
        step_t t[$];
        exp_t e;
        t.push_back(mk(0, 1, 0, 0, 1, 0, 1, 5'd8, 5'd8, 5'd0, FLUSH, 32'd5));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, LDU, 32'd5));
        t.push_back(idle(ALL, 32'd6));
        foreach (t[i]) begin
            drive(t[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if ({obs(), stall_cnt} !== {e.vec, e.cnt}) begin
                errors++;
                $display("FAIL branch_load_use step %0d: got %b cnt %h, expected %b cnt %h",
                         i, obs(), stall_cnt, e.vec, e.cnt);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_ihit_miss();
        step_t t[$];
        exp_t e;
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, IMISS, 32'd6));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, IMISS, 32'd7));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, FRZ, 32'd8));
        t.push_back(mk(0, 1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, ALL, 32'd9));
        t.push_back(idle(ALL, 32'd9));
        foreach (t[i]) begin
            drive(t[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if ({obs(), stall_cnt} !== {e.vec, e.cnt}) begin
                errors++;
                $display("FAIL ihit_miss step %0d: got %b cnt %h, expected %b cnt %h",
                         i, obs(), stall_cnt, e.vec, e.cnt);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_halt();
        step_t t[$];
        exp_t e;
        t.push_back(mk(0, 1, 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, FRZ, 32'd9));
        t.push_back(mk(0, 1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, ALL, 32'd10));
        t.push_back(idle(HALTV, 32'd10));
        t.push_back(mk(0, 0, 0, 1, 1, 0, 1, 5'd4, 5'd4, 5'd0, HALTV, 32'd10));
        t.push_back(mk(1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, RSTV | HALTV, 32'd10));
        t.push_back(idle(ALL, 32'd0));
        foreach (t[i]) begin
            drive(t[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if ({obs(), stall_cnt} !== {e.vec, e.cnt}) begin
                errors++;
                $display("FAIL halt step %0d: got %b cnt %h, expected %b cnt %h",
                         i, obs(), stall_cnt, e.vec, e.cnt);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_saturation();
        step_t t[$];
        exp_t e;
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, IMISS, 32'hFFFF_FFFE));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, IMISS, 32'hFFFF_FFFF));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, IMISS, 32'hFFFF_FFFF));
        t.push_back(idle(ALL, 32'hFFFF_FFFF));
        foreach (t[i]) begin
            drive(t[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if ({obs(), stall_cnt} !== {e.vec, e.cnt}) begin
                errors++;
                $display("FAIL saturation step %0d: got %b cnt %h, expected %b cnt %h",
                         i, obs(), stall_cnt, e.vec, e.cnt);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset_override();
        step_t t[$];
        exp_t e;
        t.push_back(mk(1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, RSTV, 32'hFFFF_FFFF));
        t.push_back(mk(0, 1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, FRZ, 32'd0));
        t.push_back(mk(1, 1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, RSTV, 32'd1));
        t.push_back(idle(ALL, 32'd0));
        foreach (t[i]) begin
            drive(t[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if ({obs(), stall_cnt} !== {e.vec, e.cnt}) begin
                errors++;
                $display("FAIL reset_override step %0d: got %b cnt %h, expected %b cnt %h",
                         i, obs(), stall_cnt, e.vec, e.cnt);
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b1; dhit = 1'b0; memreqMEM = 1'b0;
        dRENEX = 1'b0; takenEX = 1'b0; haltMEM = 1'b0;
        wselEX = '0; rsDEC = '0; rtDEC = '0;
        @(negedge CLK);
        @(negedge CLK);
        test_reset();
        test_load_use();
        test_reg_zero();
        test_branch_freeze();
        test_branch_load_use();
        test_ihit_miss();
        test_halt();
        test_saturation();
        test_reset_override();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: CLK and RST.
REQ-002 SHALL have port: CLK  in  1  rising-edge clock.
REQ-003 SHALL have port: RST  in  1  synchronous active-high reset.
REQ-004 SHALL have port: ihit  in  1  instruction fetch completes this cycle.
REQ-005 SHALL have port: dhit  in  1  data access completes this cycle.
REQ-006 SHALL have port: memreqMEM  in  1  MEM-stage instruction has dREN or dWEN.
REQ-007 SHALL have port: dRENEX  in  1  ID/EX holds a load.
REQ-008 SHALL have port: wselEX  in  5  ID/EX destination register.
REQ-009 SHALL have port: rsDEC, rtDEC  in  5 each  IF/ID source registers.
REQ-010 SHALL have port: takenEX  in  1  branch/jr resolved taken in EX.
REQ-011 SHALL have port: haltMEM  in  1  halt instruction in MEM.
REQ-012 SHALL have port: pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage advance enables.
REQ-013 SHALL have port: ifid_flush, idex_flush  out  1 each  load NOP bubble on the next edge.
REQ-014 SHALL have port: halted  out  1  sticky halt.
REQ-015 SHALL have port: stall_cnt  out  32  count of stalled cycles.

Function
REQ-016 SHALL use FSM states RUN, LDSTALL, BRPEND and HALT.
REQ-017 SHALL treat a freeze (memreqMEM && !dhit) as top-priority outside HALT: all *_en=0, all flushes=0.
REQ-018 SHALL, on freeze with takenEX=1, latch the branch: go to BRPEND, which keeps the freeze until dhit.
REQ-019 SHALL, in BRPEND with dhit=1, assert all *_en=1, ifid_flush=1 and idex_flush=1 for exactly one cycle, then go to RUN.
REQ-020 SHALL, in RUN with takenEX=1 and no freeze, assert all *_en=1, ifid_flush=1 and idex_flush=1; the state stays RUN.
REQ-021 SHALL define load-use as dRENEX && wselEX!=0 && (wselEX==rsDEC || wselEX==rtDEC).
REQ-022 SHALL, in RUN with load-use, no takenEX and no freeze: pc_en=0, ifid_en=0, idex_flush=1, EX/MEM/WB enables=1, then go to LDSTALL.
REQ-023 SHALL spend exactly one cycle in LDSTALL, acting as RUN with load-use masked; this limits each load to one bubble.
REQ-024 SHALL give takenEX priority when it coincides with load-use; the load-use stall is discarded.
REQ-025 SHALL, with ihit=0 and no other event: pc_en=0, ifid_en=1, ifid_flush=1, downstream enables=1.
REQ-026 SHALL go to HALT on the edge where haltMEM=1 and exmem_en=1.
REQ-027 SHALL hold in HALT (exited only by RST): all *_en=0, flushes=0, halted=1.
REQ-028 SHALL increment stall_cnt each cycle with pc_en=0 and halted=0, saturating at 32'hFFFFFFFF without wrap.
REQ-029 SHALL drive all outputs combinationally from state and inputs; state, halted and stall_cnt are registered.

Reset
REQ-030 SHALL, on RST=1 at a CLK edge, set state=RUN, halted=0 and stall_cnt=0; RST overrides every other event, including mid-freeze and BRPEND.
REQ-031 SHALL, while RST=1, force all *_en=0 and ifid_flush=idex_flush=1.

Structure
REQ-032 SHALL keep regbits_t (5-bit) and the state enum pctrl_state_t in cpu_types_pkg.
REQ-033 SHALL place the load-use comparison (REQ-021) in a combinational sub-module named hazard_detect.

Verification
REQ-034 SHALL test load-use: dRENEX=1, wselEX=8, rsDEC=8 -> one cycle with pc_en=0 and idex_flush=1, then RUN, stall_cnt=1.
REQ-035 SHALL test reg-zero: dRENEX=1, wselEX=0, rtDEC=0 -> no stall, all enables=1.
REQ-036 SHALL test branch under freeze: takenEX=1 while memreqMEM=1 and dhit=0 for 3 cycles -> 3 frozen cycles, then one cycle with both flushes=1, then RUN.
REQ-037 SHALL test branch with load-use: takenEX=1 and load-use together -> flushes=1, pc_en=1, state stays RUN.
REQ-038 SHALL test halt: haltMEM=1 with exmem_en=1 -> halted=1 next cycle, all enables 0, stall_cnt frozen; RST=1 -> RUN and stall_cnt=0.
REQ-039 SHALL test saturation: stall_cnt preloaded to 32'hFFFFFFFE, then 3 stalled cycles -> 32'hFFFFFFFF.
